// File: rtl/if_fetch_buffer.sv
// rtl/if_fetch_buffer.sv - instruction fetch stage with a small decoupling queue toward decode
module if_fetch_buffer #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOOP  = 32'h47ff041f
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              Icache_data_out,
  input  logic                     Icache_valid_out,
  input  logic                     ex_take_branch,
  input  logic [63:0]              ex_target_pc,
  input  logic                     id_ready,
  output logic [63:0]              proc2Icache_addr,
  output logic [31:0]              if_inst_out,
  output logic [63:0]              if_pc_out,
  output logic [63:0]              if_npc_out,
  output logic                     if_valid_out,
  output logic [$clog2(DEPTH):0]   if_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_q [DEPTH];
  logic [63:0]   pc_q   [DEPTH];

  logic          pop;
  logic [CW:0]   free;
  logic [1:0]    push;
  logic [31:0]   sel_inst;
  logic [PW-1:0] tail_p1;

  // Low address bits of a redirect target are forced to zero, so they are never read.
  logic unused_target_bits;
  assign unused_target_bits = &{1'b0, ex_target_pc[1:0]};

  assign pop      = if_valid_out && id_ready;
  // A slot vacated by this cycle's pop is usable by this cycle's push.
  assign free     = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
  assign sel_inst = fetch_pc_q[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];
  assign tail_p1  = tail_q + PW'(1);

  // Push decision and fetch PC advance, in redirect > miss > dual > single priority.
  always_comb begin
    push       = 2'd0;
    fetch_pc_d = fetch_pc_q;
    if (ex_take_branch) begin
      fetch_pc_d = {ex_target_pc[63:2], 2'b00};
    end else if (!Icache_valid_out) begin
      push = 2'd0;
    end else if (!fetch_pc_q[2] && (free >= (CW+1)'(2))) begin
      push       = 2'd2;
      fetch_pc_d = fetch_pc_q + 64'd8;
    end else if (free >= (CW+1)'(1)) begin
      push       = 2'd1;
      fetch_pc_d = fetch_pc_q + 64'd4;
    end
  end

  // Queue pointer and occupancy bookkeeping; a redirect empties the queue.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    if (ex_take_branch) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state registers; reset outranks a redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= 64'd0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; entries past the pointers are don't-care so no reset is needed.
  always_ff @(posedge clock) begin
    if (push != 2'd0) begin
      inst_q[tail_q] <= sel_inst;
      pc_q[tail_q]   <= fetch_pc_q;
    end
    if (push == 2'd2) begin
      inst_q[tail_p1] <= Icache_data_out[63:32];
      pc_q[tail_p1]   <= fetch_pc_q + 64'd4;
    end
  end

  // Head-of-queue presentation, substituting NOOP/zero while empty.
  always_comb begin
    if_valid_out     = (count_q != '0);
    if_count         = count_q;
    proc2Icache_addr = fetch_pc_q;
    if_inst_out      = NOOP;
    if_pc_out        = 64'd0;
    if_npc_out       = 64'd0;
    if (if_valid_out) begin
      if_inst_out = inst_q[head_q];
      if_pc_out   = pc_q[head_q];
      if_npc_out  = pc_q[head_q] + 64'd4;
    end
  end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb/tb_if_fetch_buffer.sv - directed and model-checked bench for if_fetch_buffer
module tb_if_fetch_buffer;

  localparam logic [31:0] NOOP = 32'h47ff041f;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic        ex_take_branch;
  logic [63:0] ex_target_pc;
  logic        id_ready;
  logic [63:0] proc2Icache_addr;
  logic [31:0] if_inst_out;
  logic [63:0] if_pc_out;
  logic [63:0] if_npc_out;
  logic        if_valid_out;
  logic [2:0]  if_count;

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_buffer #(.DEPTH(4), .NOOP(NOOP)) dut (
    .clock(clock), .reset(reset),
    .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
    .ex_take_branch(ex_take_branch), .ex_target_pc(ex_target_pc),
    .id_ready(id_ready), .proc2Icache_addr(proc2Icache_addr),
    .if_inst_out(if_inst_out), .if_pc_out(if_pc_out), .if_npc_out(if_npc_out),
    .if_valid_out(if_valid_out), .if_count(if_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] p);
    return p[31:0] ^ p[63:32] ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk_head(input string tag, input logic [2:0] cnt, input logic [63:0] addr,
                          input logic [63:0] pc, input logic [31:0] inst);
    chk({tag, "_count"}, 64'(if_count), 64'(cnt));
    chk({tag, "_addr"}, proc2Icache_addr, addr);
    chk({tag, "_pc"}, if_pc_out, pc);
    chk({tag, "_inst"}, 64'(if_inst_out), 64'(inst));
  endtask

  logic [63:0] exp_pc, prev_addr, tgt, a8;
  logic        prev_hold, rst_r, br_r, rdy_r, hit_r;

  initial begin
    reset = 1'b1; Icache_data_out = '0; Icache_valid_out = 1'b0;
    ex_take_branch = 1'b0; ex_target_pc = '0; id_ready = 1'b0;
    step(); step();
    chk("rst_addr", proc2Icache_addr, 64'd0);
    chk("rst_valid", 64'(if_valid_out), 64'd0);
    chk("rst_inst", 64'(if_inst_out), 64'(NOOP));
    chk("rst_pc", if_pc_out, 64'd0);
    chk("rst_npc", if_npc_out, 64'd0);
    chk("rst_count", 64'(if_count), 64'd0);

    // First hit at address 0, queue empty: visible one cycle later.
    reset = 1'b0; Icache_valid_out = 1'b1; Icache_data_out = 64'hBBBBBBBB_AAAAAAAA; id_ready = 1'b1;
    chk("hit0_addr_before", proc2Icache_addr, 64'd0);
    step();
    chk_head("hit0", 3'd2, 64'd8, 64'd0, 32'hAAAAAAAA);
    chk("hit0_npc", if_npc_out, 64'd4);

    // Back-pressure fills the queue and freezes the fetch address.
    reset = 1'b1; step();
    reset = 1'b0; id_ready = 1'b0;
    step(); chk_head("fill1", 3'd2, 64'd8, 64'd0, 32'hAAAAAAAA);
    step(); chk_head("fill2", 3'd4, 64'd16, 64'd0, 32'hAAAAAAAA);
    step(); chk_head("fill3", 3'd4, 64'd16, 64'd0, 32'hAAAAAAAA);
    // Full queue with a pop: one push into the freed slot, count stays full.
    id_ready = 1'b1;
    step(); chk_head("full_pop", 3'd4, 64'd20, 64'd4, 32'hBBBBBBBB);

    // Redirect to an odd word (low bits ignored).
    id_ready = 1'b0; ex_take_branch = 1'b1; ex_target_pc = 64'h107;
    step();
    chk_head("redir", 3'd0, 64'h104, 64'd0, NOOP);
    chk("redir_valid", 64'(if_valid_out), 64'd0);
    chk("redir_npc", if_npc_out, 64'd0);
    ex_take_branch = 1'b0; Icache_data_out = 64'h22222222_11111111;
    step();
    chk_head("odd", 3'd1, 64'h108, 64'h104, 32'h22222222);
    chk("odd_npc", if_npc_out, 64'h108);
    step();
    chk_head("odd_dual", 3'd3, 64'h110, 64'h104, 32'h22222222);

    // Redirect concurrent with a pop at count 3.
    id_ready = 1'b1; ex_take_branch = 1'b1; ex_target_pc = 64'h200;
    step();
    chk_head("redir_pop", 3'd0, 64'h200, 64'd0, NOOP);
    chk("redir_pop_valid", 64'(if_valid_out), 64'd0);

    // Five-cycle miss then a hit.
    ex_take_branch = 1'b0; id_ready = 1'b0; Icache_valid_out = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("miss_addr", proc2Icache_addr, 64'h200);
      chk("miss_count", 64'(if_count), 64'd0);
    end
    Icache_valid_out = 1'b1; Icache_data_out = 64'h44444444_33333333;
    step();
    chk_head("miss_hit", 3'd2, 64'h208, 64'h200, 32'h33333333);

    // PC wrap at the top of the address space.
    ex_take_branch = 1'b1; ex_target_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("wrap_addr0", proc2Icache_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ex_take_branch = 1'b0; Icache_data_out = 64'h66666666_55555555;
    step();
    chk_head("wrap", 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h66666666);
    chk("wrap_npc", if_npc_out, 64'd0);

    // Randomized traffic checked against an in-order expected PC stream.
    reset = 1'b1; ex_take_branch = 1'b0; Icache_valid_out = 1'b0; id_ready = 1'b0;
    step();
    exp_pc = 64'd0; prev_hold = 1'b0; prev_addr = 64'd0;
    for (int i = 0; i < 1000; i++) begin
      rst_r = (i == 400) || (i == 750) || (i == 0);
      br_r  = !rst_r && ($urandom_range(0, 99) < 4);
      rdy_r = ($urandom_range(0, 99) < 60);
      hit_r = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'({$urandom_range(0, 3), 2'b00});
      else tgt = {32'd0, $urandom} & ~64'h3;
      reset = rst_r; ex_take_branch = br_r; ex_target_pc = tgt;
      id_ready = rdy_r; Icache_valid_out = hit_r;
      a8 = proc2Icache_addr & ~64'h7;
      Icache_data_out = {inst_of(a8 + 64'd4), inst_of(a8)};
      if (prev_hold) chk("rnd_hold_addr", proc2Icache_addr, prev_addr);
      chk("rnd_count_bound", 64'(if_count <= 3'd4), 64'd1);
      chk("rnd_valid_vs_count", 64'(if_valid_out), 64'(if_count != 3'd0));
      if (if_valid_out && rdy_r) begin
        chk("rnd_pc", if_pc_out, exp_pc);
        chk("rnd_inst", 64'(if_inst_out), 64'(inst_of(exp_pc)));
        chk("rnd_npc", if_npc_out, exp_pc + 64'd4);
        exp_pc = exp_pc + 64'd4;
      end
      if (rst_r) exp_pc = 64'd0;
      else if (br_r) exp_pc = tgt;
      prev_hold = !rst_r && !br_r && !hit_r;
      prev_addr = proc2Icache_addr;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Instruction fetch stage with a small decoupling queue. It drives the fetch address into the instruction cache controller and consumes that controller's 64-bit data/valid response. Each 64-bit word holds two 32-bit Alpha instructions; the block extracts one or two of them and queues them for decode. It also absorbs branch redirects from execute and applies back-pressure from decode.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- NOOP, 32'h47ff041f: instruction presented when the queue is empty
- clock  in  1  single clock; every register updates on posedge
- reset  in  1  synchronous, active-high
- Icache_data_out  in  64  cache word for the current proc2Icache_addr
- Icache_valid_out  in  1  Icache_data_out is valid this cycle
- ex_take_branch  in  1  redirect request from execute
- ex_target_pc  in  64  redirect target; bits [1:0] ignored and treated as 0
- id_ready  in  1  decode accepts the head instruction this cycle
- proc2Icache_addr  out  64  fetch PC, driven combinationally from fetch_pc
- if_inst_out  out  32  head instruction, or NOOP when empty
- if_pc_out  out  64  PC of the head instruction, or 0 when empty
- if_npc_out  out  64  if_pc_out + 4, or 0 when empty
- if_valid_out  out  1  queue is not empty
- if_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- State: fetch_pc[63:0]; circular queue of {inst[31:0], pc[63:0]}; head and tail pointers wrap mod DEPTH; count.
- Instruction select: fetch_pc[2]=0 selects Icache_data_out[31:0]; fetch_pc[2]=1 selects [63:32].
- pop = if_valid_out && id_ready.
- free = DEPTH − count + pop. A slot vacated by a pop can be reused in the same cycle.
- Push rules, evaluated in priority order each cycle:
  - ex_take_branch=1: push 0. Queue cleared (count, head, tail ← 0). fetch_pc ← {ex_target_pc[63:2],2'b0}. Any pop this cycle still counts as consumed.
  - Icache_valid_out=0: push 0; fetch_pc holds.
  - fetch_pc[2]=0 and free ≥ 2: push 2. Low word at tail, then high word at tail+1 with pc = fetch_pc+4. fetch_pc += 8.
  - free ≥ 1: push 1 (the selected word). fetch_pc += 4.
  - Otherwise: push 0; fetch_pc holds.
- count_next = count + push − pop (0 on redirect). count never exceeds DEPTH and never underflows.
- When no push happens, fetch_pc and proc2Icache_addr stay stable. This keeps the cache's miss request alive and stops it seeing a changed address.
- All PC arithmetic is 64-bit modulo 2^64; wrap past 64'hFFFF_FFFF_FFFF_FFFC goes to 0.

## Timing
- Reset: fetch_pc=0, count=0, head=tail=0. Outputs during and after reset: proc2Icache_addr=0, if_valid_out=0, if_inst_out=NOOP, if_pc_out=0, if_npc_out=0, if_count=0.
- Reset asserted mid-operation discards queue contents on the next edge; it takes precedence over redirect.
- Latency: a cache hit at cycle N is visible on if_inst_out at cycle N+1 if the queue was empty. Empty-queue fetch-to-decode is 1 cycle.
- Redirect at cycle N: proc2Icache_addr=target from N+1. The first target instruction appears at the earliest N+2.
- Queue-head outputs are registered state; proc2Icache_addr is combinational from fetch_pc.
- Full queue (count=DEPTH) with id_ready=1 and a hit: 1 push plus 1 pop, and count stays at DEPTH.
- Full queue with id_ready=0: no push, fetch_pc holds.
- Wrap-around: tail reaching DEPTH−1 on a dual push places the second instruction at entry 0.

## Test plan
- Reset, then a constant hit at address 0 with data 64'hBBBBBBBB_AAAAAAAA and id_ready=1 → cycle 1: inst=AAAAAAAA, pc=0, npc=4; proc2Icache_addr advances 0→8.
- id_ready=0 with continuous hits starting at PC 0 (DEPTH=4) → count goes 2, 4, then stays 4; proc2Icache_addr holds at 16.
- Odd start: redirect to 64'h104 → proc2Icache_addr=104, single push of data[63:32], next address 108.
- Redirect asserted together with a pop while count=3 → next cycle count=0, if_valid_out=0, inst=NOOP, proc2Icache_addr=target.
- Icache_valid_out=0 for 5 cycles, then 1 → proc2Icache_addr is stable through the miss; the push happens only on the hit cycle.
- Random id_ready and hits over 1000 cycles against a reference model → emitted pc sequence is strictly +4 between redirects, with no loss or duplication; checked across pointer wrap and reset mid-stream.
